// File: rtl/indirect_access_cntrl.sv
// Indirect-access controller: turns CSR command writes into single-port
// table memory operations (read, write, compare, reset-fill, init-fill).
module indirect_access_cntrl #(
    parameter logic [10:0]            CMND_ADDRESS = 11'h1B8,
    parameter logic [10:0]            STAT_ADDRESS = 11'h1AC,
    parameter int unsigned            N_DATA_BITS  = 38,
    parameter int unsigned            N_ENTRIES    = 16384,
    parameter int unsigned            N_TIMER_BITS = 6,
    parameter int unsigned            N_TABLES     = 1,
    parameter logic [15:0]            CAPABILITIES = 16'hC17F,
    parameter logic [3:0]             MEM_TYPE     = 4'd0,
    parameter logic [N_DATA_BITS-1:0] RESET_DATA   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_stb,
    input  logic [10:0]               reg_addr,
    input  logic [3:0]                cmnd_op,
    input  logic [$clog2(N_ENTRIES)-1:0] cmnd_addr,
    input  logic                      cmnd_table_id,
    output logic [2:0]                stat_code,
    output logic [4:0]                stat_datawords,
    output logic [$clog2(N_ENTRIES)-1:0] stat_addr,
    output logic                      stat_table_id,
    output logic [15:0]               capability_lst,
    output logic [3:0]                capability_type,
    output logic                      enable,
    input  logic [$clog2(N_ENTRIES)-1:0] addr_limit,
    input  logic [N_DATA_BITS-1:0]    wr_dat,
    output logic [N_DATA_BITS-1:0]    rd_dat,
    output logic                      sw_cs,
    output logic                      sw_ce,
    output logic                      sw_we,
    output logic [$clog2(N_ENTRIES)-1:0] sw_add,
    output logic [N_DATA_BITS-1:0]    sw_wdat,
    input  logic [N_DATA_BITS-1:0]    sw_rdat,
    input  logic                      sw_match,
    input  logic [$clog2(N_ENTRIES)-2:0] sw_aindex,
    input  logic                      grant,
    input  logic                      rsp,
    output logic                      yield,
    output logic                      reset
);

    localparam int unsigned AW = $clog2(N_ENTRIES);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_READ      = 4'd1;
    localparam logic [3:0] OP_WRITE     = 4'd2;
    localparam logic [3:0] OP_ENABLE    = 4'd3;
    localparam logic [3:0] OP_DISABLE   = 4'd4;
    localparam logic [3:0] OP_RESET     = 4'd5;
    localparam logic [3:0] OP_INIT      = 4'd6;
    localparam logic [3:0] OP_INIT_INC  = 4'd7;
    localparam logic [3:0] OP_SET_START = 4'd8;
    localparam logic [3:0] OP_COMPARE   = 4'd9;
    localparam logic [3:0] OP_SIM_TMO   = 4'd14;
    localparam logic [3:0] OP_ACK_ERROR = 4'd15;

    localparam logic [2:0] ST_RDY = 3'd0;
    localparam logic [2:0] ST_BSY = 3'd1;
    localparam logic [2:0] ST_TMO = 3'd2;
    localparam logic [2:0] ST_OVR = 3'd3;
    localparam logic [2:0] ST_NXM = 3'd4;
    localparam logic [2:0] ST_UOP = 3'd5;
    localparam logic [2:0] ST_PDN = 3'd7;

    typedef enum logic [3:0] {
        POWERDOWN, READY, ERROR, DO_RESET, DO_INIT, DO_WRITE,
        DO_READ, READ_DONE, DO_COMPARE, COMPARE_DONE
    } state_t;

    state_t                  state, next_state;
    logic [2:0]              stat_nxt;
    logic                    cmd_dec, cmnd_issued, uop, badaddr, igrant, timeout;
    logic                    busy_st, mem_nxt;
    logic [15:0]             op_hot;
    logic [AW-1:0]           maxaddr, rst_addr;
    logic                    init, sim_tmo, rst_r, rst_or_ini;
    logic [N_TIMER_BITS-1:0] timer;
    logic                    unused_ok;

    // Command decode and derived qualifiers
    assign cmd_dec     = wr_stb && (reg_addr == CMND_ADDRESS);
    assign op_hot      = cmd_dec ? (16'(1) << cmnd_op) : 16'(0);
    assign uop         = |op_hot[13:10];
    assign cmnd_issued = cmd_dec && (cmnd_op != OP_NOP) && (cmnd_op != OP_SIM_TMO);
    assign maxaddr     = init ? AW'(0) : addr_limit;
    assign badaddr     = cmnd_issued && (cmnd_addr > maxaddr);
    assign igrant      = grant && !sim_tmo;
    assign timeout     = (timer == {N_TIMER_BITS{1'b1}});
    assign busy_st     = state inside {DO_RESET, DO_INIT, DO_WRITE, DO_READ,
                                       READ_DONE, DO_COMPARE, COMPARE_DONE};
    assign mem_nxt     = next_state inside {DO_RESET, DO_INIT, DO_WRITE, DO_READ, DO_COMPARE};

    // Static and pass-through outputs
    assign sw_add          = rst_or_ini ? rst_addr : cmnd_addr;
    assign sw_wdat         = rst_r ? RESET_DATA : wr_dat;
    assign stat_addr       = maxaddr;
    assign stat_datawords  = 5'd1;
    assign stat_table_id   = 1'b0;
    assign capability_lst  = CAPABILITIES;
    assign capability_type = MEM_TYPE;
    assign enable          = !init;
    assign yield           = timer[N_TIMER_BITS-1];
    assign reset           = rst_or_ini;
    assign unused_ok       = ^{cmnd_table_id, STAT_ADDRESS, 1'(N_TABLES)};

    // Next-state and next-status selection
    always_comb begin
        next_state = state;
        stat_nxt   = stat_code;
        case (state)
            POWERDOWN:    if (op_hot[OP_ENABLE]) next_state = READY;
            READY: begin
                if      (op_hot[OP_WRITE])                      next_state = DO_WRITE;
                else if (op_hot[OP_READ])                       next_state = DO_READ;
                else if (op_hot[OP_COMPARE])                    next_state = DO_COMPARE;
                else if (op_hot[OP_RESET])                      next_state = DO_RESET;
                else if (op_hot[OP_INIT] || op_hot[OP_INIT_INC]) next_state = DO_INIT;
                else if (op_hot[OP_DISABLE])                    next_state = POWERDOWN;
                else if (uop)                                   next_state = ERROR;
            end
            DO_WRITE:     if (igrant) next_state = READY;
            DO_READ:      if (igrant) next_state = READ_DONE;
            DO_COMPARE:   if (igrant) next_state = COMPARE_DONE;
            DO_RESET:     if (igrant && rst_addr == maxaddr)   next_state = READY;
            DO_INIT:      if (igrant && rst_addr == cmnd_addr) next_state = READY;
            READ_DONE:    if (rsp) next_state = READY;
            COMPARE_DONE: if (rsp) next_state = READY;
            ERROR:        if (op_hot[OP_ACK_ERROR]) next_state = init ? POWERDOWN : READY;
            default:      next_state = ERROR;
        endcase
        if (badaddr || (busy_st && (timeout || cmnd_issued)))
            next_state = ERROR;

        case (next_state)
            POWERDOWN: stat_nxt = ST_PDN;
            READY:     stat_nxt = ST_RDY;
            ERROR: begin
                if (state != ERROR) begin
                    if      (uop)     stat_nxt = ST_UOP;
                    else if (badaddr) stat_nxt = ST_NXM;
                    else if (timeout) stat_nxt = ST_TMO;
                    else              stat_nxt = ST_OVR;
                end
            end
            default:   stat_nxt = ST_BSY;
        endcase
    end

    // State, status, init flag and memory strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= POWERDOWN;
            stat_code  <= ST_PDN;
            init       <= 1'b1;
            sw_cs      <= 1'b0;
            sw_ce      <= 1'b0;
            sw_we      <= 1'b0;
            rst_r      <= 1'b0;
            rst_or_ini <= 1'b0;
        end else begin
            state     <= next_state;
            stat_code <= stat_nxt;
            if (next_state == POWERDOWN && state != POWERDOWN)
                init <= 1'b1;
            else if (state == POWERDOWN && next_state == READY)
                init <= 1'b0;
            sw_cs      <= mem_nxt;
            sw_ce      <= (next_state == DO_COMPARE);
            sw_we      <= next_state inside {DO_WRITE, DO_RESET, DO_INIT};
            rst_r      <= (next_state == DO_RESET);
            rst_or_ini <= next_state inside {DO_RESET, DO_INIT};
        end
    end

    // Fill address pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_addr <= '0;
        else if (op_hot[OP_SET_START])
            rst_addr <= cmnd_addr;
        else if (op_hot[OP_RESET])
            rst_addr <= '0;
        else if ((state == DO_RESET || state == DO_INIT) && igrant)
            rst_addr <= rst_addr + AW'(1);
    end

    // Grant-wait timer and simulated-timeout latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            sim_tmo <= 1'b0;
        end else begin
            timer <= (mem_nxt && !igrant) ? timer + N_TIMER_BITS'(1) : '0;
            if (timeout)
                sim_tmo <= 1'b0;
            else if (op_hot[OP_SIM_TMO])
                sim_tmo <= 1'b1;
        end
    end

    // Read-back data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_dat <= '0;
        else if (state == POWERDOWN)
            rd_dat <= wr_dat;
        else if (state == READ_DONE && rsp)
            rd_dat <= sw_rdat;
        else if (state == COMPARE_DONE && rsp)
            rd_dat <= N_DATA_BITS'({sw_match, sw_aindex});
    end

`ifndef SYNTHESIS
    // Flag operations left outstanding at end of simulation
    final begin
        if (stat_code == ST_BSY)
            $warning("wait for completion");
        else if (stat_code != ST_RDY && stat_code != ST_PDN)
            $warning("acknowledge error");
    end
`endif

endmodule

// File: tb/tb_indirect_access_cntrl.sv
// Directed self-checking bench for indirect_access_cntrl.
module tb_indirect_access_cntrl;

    localparam logic [10:0] CMND = 11'h1B8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_stb;
    logic [10:0] reg_addr;
    logic [3:0]  cmnd_op;
    logic [13:0] cmnd_addr;
    logic        cmnd_table_id;
    logic [2:0]  stat_code;
    logic [4:0]  stat_datawords;
    logic [13:0] stat_addr;
    logic        stat_table_id;
    logic [15:0] capability_lst;
    logic [3:0]  capability_type;
    logic        enable;
    logic [13:0] addr_limit;
    logic [37:0] wr_dat, rd_dat, sw_wdat, sw_rdat;
    logic        sw_cs, sw_ce, sw_we, sw_match, grant, rsp, yield, reset;
    logic [13:0] sw_add;
    logic [12:0] sw_aindex;

    int total = 0;
    int bad   = 0;

    indirect_access_cntrl dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .reg_addr(reg_addr),
        .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id),
        .stat_code(stat_code), .stat_datawords(stat_datawords), .stat_addr(stat_addr),
        .stat_table_id(stat_table_id), .capability_lst(capability_lst),
        .capability_type(capability_type), .enable(enable), .addr_limit(addr_limit),
        .wr_dat(wr_dat), .rd_dat(rd_dat), .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
        .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .sw_match(sw_match),
        .sw_aindex(sw_aindex), .grant(grant), .rsp(rsp), .yield(yield), .reset(reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one command for a single cycle; returns at the following negedge
    task automatic issue(input logic [3:0] op, input logic [13:0] a);
        wr_stb = 1'b1; reg_addr = CMND; cmnd_op = op; cmnd_addr = a;
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; wr_stb = 1'b0; reg_addr = '0; cmnd_op = '0; cmnd_addr = '0;
        cmnd_table_id = 1'b0; addr_limit = 14'd100; wr_dat = '0; sw_rdat = '0;
        sw_match = 1'b0; sw_aindex = '0; grant = 1'b0; rsp = 1'b0;
        repeat (3) tick();
        chk("rst_stat", 64'(stat_code), 64'd7);
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_rd_dat", 64'(rd_dat), 64'd0);
        chk("rst_strobes", 64'({sw_cs, sw_ce, sw_we, reset, yield}), 64'd0);
        chk("rst_maxaddr", 64'(stat_addr), 64'd0);
        chk("cap_lst", 64'(capability_lst), 64'hC17F);
        chk("datawords", 64'(stat_datawords), 64'd1);
        wr_dat = 38'h55;
        rst_n  = 1'b1;
        tick();
        chk("pdn_rd_follow", 64'(rd_dat), 64'h55);

        // Nonzero address while powered down is out of range
        issue(4'd1, 14'd1);
        chk("pdn_nxm", 64'(stat_code), 64'd4);
        issue(4'd15, 14'd0);
        chk("ack_to_pdn", 64'(stat_code), 64'd7);
        chk("ack_to_pdn_en", 64'(enable), 64'd0);

        issue(4'd3, 14'd0);
        chk("enable_stat", 64'(stat_code), 64'd0);
        chk("enable_en", 64'(enable), 64'd1);
        chk("enable_maxaddr", 64'(stat_addr), 64'd100);

        // Single-cycle write with grant already high
        grant = 1'b1; wr_dat = 38'h12345;
        issue(4'd2, 14'd5);
        chk("wr_strobes", 64'({sw_cs, sw_we, sw_ce}), 64'b110);
        chk("wr_add", 64'(sw_add), 64'd5);
        chk("wr_wdat", 64'(sw_wdat), 64'h12345);
        chk("wr_busy", 64'(stat_code), 64'd1);
        tick();
        chk("wr_done", 64'(stat_code), 64'd0);
        chk("wr_cs_off", 64'(sw_cs), 64'd0);

        // Read with response
        issue(4'd1, 14'd7);
        chk("rd_strobes", 64'({sw_cs, sw_we, sw_ce}), 64'b100);
        tick();
        chk("rd_wait", 64'({stat_code, sw_cs}), 64'b0010);
        rsp = 1'b1; sw_rdat = 38'h3F_FFFF_FFFF;
        tick();
        rsp = 1'b0;
        chk("rd_dat", 64'(rd_dat), 64'h3F_FFFF_FFFF);
        chk("rd_done", 64'(stat_code), 64'd0);

        // Compare with hit
        sw_match = 1'b1; sw_aindex = 13'h1ABC;
        issue(4'd9, 14'd2);
        chk("cmp_strobes", 64'({sw_cs, sw_we, sw_ce}), 64'b101);
        tick();
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        chk("cmp_rd_dat", 64'(rd_dat), 64'h3ABC);
        chk("cmp_done", 64'(stat_code), 64'd0);

        // Reset-fill over addresses 0..3
        addr_limit = 14'd3; wr_dat = 38'h2AAAA;
        issue(4'd5, 14'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rf_add", 64'(sw_add), 64'(i));
            chk("rf_flags", 64'({sw_cs, sw_we, reset}), 64'b111);
            chk("rf_wdat", 64'(sw_wdat), 64'd0);
            tick();
        end
        chk("rf_done", 64'(stat_code), 64'd0);
        chk("rf_reset_off", 64'({reset, sw_cs}), 64'd0);

        // Init-fill from start 1 to end 2
        wr_dat = 38'h777;
        issue(4'd8, 14'd1);
        chk("set_start", 64'(stat_code), 64'd0);
        issue(4'd6, 14'd2);
        chk("if_add0", 64'(sw_add), 64'd1);
        chk("if_wdat", 64'(sw_wdat), 64'h777);
        chk("if_reset", 64'(reset), 64'd1);
        tick();
        chk("if_add1", 64'(sw_add), 64'd2);
        tick();
        chk("if_done", 64'(stat_code), 64'd0);

        // Grant timeout
        addr_limit = 14'd100; grant = 1'b0;
        issue(4'd2, 14'd5);
        chk("tmo_yield0", 64'(yield), 64'd0);
        repeat (62) tick();
        chk("tmo_busy", 64'(stat_code), 64'd1);
        chk("tmo_yield1", 64'(yield), 64'd1);
        tick();
        chk("tmo_stat", 64'(stat_code), 64'd2);
        chk("tmo_cs_off", 64'(sw_cs), 64'd0);
        issue(4'd15, 14'd0);
        chk("tmo_ack", 64'(stat_code), 64'd0);

        // Simulated timeout masks grant until the timeout fires
        grant = 1'b1;
        issue(4'd14, 14'd0);
        chk("simtmo_rdy", 64'(stat_code), 64'd0);
        issue(4'd2, 14'd5);
        tick();
        chk("simtmo_held", 64'(stat_code), 64'd1);
        repeat (61) tick();
        chk("simtmo_busy", 64'(stat_code), 64'd1);
        tick();
        chk("simtmo_tmo", 64'(stat_code), 64'd2);
        issue(4'd15, 14'd0);
        issue(4'd2, 14'd5);
        tick();
        chk("simtmo_cleared", 64'(stat_code), 64'd0);

        // Unsupported opcode
        issue(4'd10, 14'd0);
        chk("uop", 64'(stat_code), 64'd5);
        issue(4'd15, 14'd0);
        chk("uop_ack", 64'(stat_code), 64'd0);

        // Overlapping command while busy
        grant = 1'b0;
        issue(4'd1, 14'd0);
        chk("ovr_busy", 64'(stat_code), 64'd1);
        issue(4'd2, 14'd0);
        chk("ovr", 64'(stat_code), 64'd3);
        issue(4'd15, 14'd0);
        chk("ovr_ack", 64'(stat_code), 64'd0);

        // Address range boundary
        issue(4'd2, 14'd101);
        chk("nxm", 64'(stat_code), 64'd4);
        issue(4'd1, 14'd0);
        chk("err_hold", 64'(stat_code), 64'd4);
        issue(4'd15, 14'd0);
        chk("nxm_ack", 64'(stat_code), 64'd0);
        grant = 1'b1;
        issue(4'd2, 14'd100);
        chk("limit_ok", 64'(stat_code), 64'd1);
        chk("limit_add", 64'(sw_add), 64'd100);
        tick();
        chk("limit_done", 64'(stat_code), 64'd0);

        // Disable then re-enable
        issue(4'd4, 14'd0);
        chk("dis_stat", 64'(stat_code), 64'd7);
        chk("dis_en", 64'(enable), 64'd0);
        chk("dis_maxaddr", 64'(stat_addr), 64'd0);
        issue(4'd3, 14'd0);
        chk("reen_stat", 64'(stat_code), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
